// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : MIPS instruction fetch stage. Owns the PC, issues one word read
//             at a time and hands {instr, pc, pc+4} to decode.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          PC_STEP      = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  input  logic        if_ready,
  output logic        misalign_err,
  output logic [15:0] drop_count
);

  localparam logic [1:0]  c_IDLE = 2'd0;
  localparam logic [1:0]  c_REQ  = 2'd1;
  localparam logic [1:0]  c_WAIT = 2'd2;
  localparam logic [1:0]  c_OUT  = 2'd3;
  localparam logic [31:0] c_STEP = 32'(PC_STEP);

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic        r_drop_pending;
  logic        r_misalign;
  logic [15:0] r_drop_count;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_pc_plus4;

  logic [31:0] w_target;
  logic [31:0] w_pc_seq;
  logic [15:0] w_drop_inc;

  assign w_target   = {redirect_target[31:2], 2'b00};
  assign w_pc_seq   = r_pc + c_STEP;
  assign w_drop_inc = (r_drop_count == 16'hFFFF) ? r_drop_count : r_drop_count + 16'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= c_IDLE;
      r_pc           <= RESET_VECTOR;
      r_drop_pending <= 1'b0;
      r_misalign     <= 1'b0;
      r_drop_count   <= 16'd0;
      r_if_instr     <= 32'd0;
      r_if_pc        <= 32'd0;
      r_if_pc_plus4  <= 32'd0;
    end else begin
      if (redirect_valid && (redirect_target[1:0] != 2'b00))
        r_misalign <= 1'b1;

      case (r_state)
        c_IDLE: begin
          if (redirect_valid)
            r_pc <= w_target;
          r_state <= c_REQ;
        end

        c_REQ: begin
          if (redirect_valid)
            r_pc <= w_target;
          // A redirect coincident with acceptance leaves a stale word in flight.
          if (imem_req_ready) begin
            r_state        <= c_WAIT;
            r_drop_pending <= redirect_valid;
          end
        end

        c_WAIT: begin
          if (redirect_valid)
            r_pc <= w_target;
          if (imem_resp_valid) begin
            if (redirect_valid || r_drop_pending) begin
              r_drop_pending <= 1'b0;
              r_drop_count   <= w_drop_inc;
              r_state        <= c_REQ;
            end else begin
              r_if_instr    <= imem_resp_data;
              r_if_pc       <= r_pc;
              r_if_pc_plus4 <= w_pc_seq;
              r_state       <= c_OUT;
            end
          end else if (redirect_valid) begin
            r_drop_pending <= 1'b1;
          end
        end

        c_OUT: begin
          // Redirect wins over a same-cycle decode handshake.
          if (redirect_valid) begin
            r_pc         <= w_target;
            r_drop_count <= w_drop_inc;
            r_state      <= c_REQ;
          end else if (if_ready) begin
            r_pc    <= w_pc_seq;
            r_state <= c_REQ;
          end
        end

        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign imem_req_valid = (r_state == c_REQ);
  assign imem_req_addr  = r_pc;
  assign if_valid       = (r_state == c_OUT);
  assign if_instr       = r_if_instr;
  assign if_pc          = r_if_pc;
  assign if_pc_plus4    = r_if_pc_plus4;
  assign misalign_err   = r_misalign;
  assign drop_count     = r_drop_count;

endmodule
`default_nettype wire
